// File: rtl/usb_link_pkg.sv
// rtl/usb_link_pkg.sv - shared PID constants, FSM state type and PID class helpers
package usb_link_pkg;

  localparam logic [3:0] PID_OUT   = 4'b0001;
  localparam logic [3:0] PID_IN    = 4'b1001;
  localparam logic [3:0] PID_SETUP = 4'b1101;
  localparam logic [3:0] PID_DATA0 = 4'b0011;
  localparam logic [3:0] PID_DATA1 = 4'b1011;
  localparam logic [3:0] PID_ACK   = 4'b0010;
  localparam logic [3:0] PID_NAK   = 4'b1010;
  localparam logic [3:0] PID_STALL = 4'b1110;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TX_TOKEN,
    ST_TX_DATA,
    ST_WAIT_DATA,
    ST_WAIT_HS,
    ST_TURN,
    ST_TX_HS
  } link_state_t;

  function automatic logic is_token(input logic [3:0] pid);
    return (pid == PID_OUT) || (pid == PID_IN) || (pid == PID_SETUP);
  endfunction

  function automatic logic is_data(input logic [3:0] pid);
    return (pid == PID_DATA0) || (pid == PID_DATA1);
  endfunction

endpackage

// File: rtl/link_toggle_bank.sv
// rtl/link_toggle_bank.sv - per-endpoint DATA0/DATA1 toggle flops with clear/flip and two read ports
module link_toggle_bank #(
  parameter int NUM_EP = 4,
  parameter int EP_W   = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  input  logic            flip,
  input  logic [EP_W-1:0] wr_idx,
  input  logic [EP_W-1:0] rd_idx_a,
  input  logic [EP_W-1:0] rd_idx_b,
  output logic            rd_a,
  output logic            rd_b
);

  logic [NUM_EP-1:0] tog_q;

  // Update only the addressed flop; an index past NUM_EP matches nothing, clear beats flip
  always_ff @(posedge clk) begin
    if (rst) begin
      tog_q <= '0;
    end else begin
      for (int i = 0; i < NUM_EP; i++) begin
        if (EP_W'(i) == wr_idx) begin
          if (clr) begin
            tog_q[i] <= 1'b0;
          end else if (flip) begin
            tog_q[i] <= ~tog_q[i];
          end
        end
      end
    end
  end

  // Read ports; an out-of-range index reads as 0 (DATA0)
  always_comb begin
    rd_a = 1'b0;
    rd_b = 1'b0;
    for (int i = 0; i < NUM_EP; i++) begin
      if (EP_W'(i) == rd_idx_a) rd_a = tog_q[i];
      if (EP_W'(i) == rd_idx_b) rd_b = tog_q[i];
    end
  end

endmodule

// File: rtl/link_control_mp.sv
// rtl/link_control_mp.sv - USB link transaction sequencer (host/device); LINK_CTRL_RETRY_EN adds retry counting
module link_control_mp
  import usb_link_pkg::*;
#(
  parameter int NUM_EP    = 4,
  parameter int EP_W      = 2,
  parameter int DELAY_W   = 6,
  parameter int TIMER_W   = 16,
  parameter int MAX_RETRY = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ms,
  input  logic [3:0]         rx_pid,
  input  logic               rx_pid_en,
  input  logic               rx_sop_en,
  input  logic [EP_W-1:0]    ep_sel,
  input  logic [DELAY_W-1:0] delay_threshold,
  input  logic [TIMER_W-1:0] time_threshold,
  input  logic [3:0]         tx_con_pid,
  input  logic               tx_con_pid_en,
  input  logic               tx_lp_eop_en,
  output logic               rx_handshake_on,
  output logic               rx_data_on,
  output logic               d_oe,
  output logic               tx_data_on,
  output logic [3:0]         tx_data_pid,
  output logic               time_out,
  output logic               toggle_err,
  output logic               retry_req,
  output logic               retry_fail
);

  link_state_t         state_q, state_d, ret_q, ret_d;
  logic [3:0]          tok_q;
  logic [EP_W-1:0]     ep_q, tog_idx;
  logic [TIMER_W-1:0]  timer_q, time_lim;
  logic [DELAY_W-1:0]  delay_q, delay_lim;
  logic                frozen_q, hold, expired, turn_done;
  logic                tog_clr, tog_flip, tog_cur, tog_sel;
  logic                to_fire, terr, nak_abort;

  // Thresholds of 0 behave as 1; the timer holds "cycles already spent" so fire one below the limit
  assign time_lim  = (time_threshold == '0) ? '0 : time_threshold - TIMER_W'(1);
  assign delay_lim = (delay_threshold == '0) ? '0 : delay_threshold - DELAY_W'(1);
  assign hold      = frozen_q | rx_sop_en;
  assign expired   = !hold && !rx_pid_en && (timer_q == time_lim);
  assign turn_done = (delay_q >= delay_lim);
  assign tog_idx   = (state_q == ST_IDLE) ? ep_sel : ep_q;

  link_toggle_bank #(.NUM_EP(NUM_EP), .EP_W(EP_W)) u_toggle (
    .clk      (clk),
    .rst      (rst),
    .clr      (tog_clr),
    .flip     (tog_flip),
    .wr_idx   (tog_idx),
    .rd_idx_a (ep_q),
    .rd_idx_b (ep_sel),
    .rd_a     (tog_cur),
    .rd_b     (tog_sel)
  );

  // Next-state and per-cycle event decode
  always_comb begin
    state_d  = state_q;
    ret_d    = ret_q;
    to_fire  = 1'b0;
    terr     = 1'b0;
    tog_clr  = 1'b0;
    tog_flip = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ms) begin
          if (tx_con_pid_en && is_token(tx_con_pid)) begin
            state_d = ST_TX_TOKEN;
            tog_clr = (tx_con_pid == PID_SETUP);
          end
        end else if (rx_pid_en && is_token(rx_pid)) begin
          tog_clr = (rx_pid == PID_SETUP);
          if (rx_pid == PID_IN) begin
            state_d = ST_TURN;
            ret_d   = ST_TX_DATA;
          end else begin
            state_d = ST_WAIT_DATA;
          end
        end
      end
      ST_TX_TOKEN: if (tx_lp_eop_en) state_d = (tok_q == PID_IN) ? ST_WAIT_DATA : ST_TX_DATA;
      ST_TX_DATA:  if (tx_lp_eop_en) state_d = ST_WAIT_HS;
      ST_WAIT_DATA: begin
        if (rx_pid_en && is_data(rx_pid)) begin
          state_d = ST_TURN;
          ret_d   = ST_TX_HS;
          if (rx_pid[3] == tog_cur) tog_flip = 1'b1;
          else                      terr     = 1'b1;
        end else if (nak_abort) begin
          state_d = ST_IDLE;
        end else if (expired) begin
          state_d = ST_IDLE;
          to_fire = 1'b1;
        end
      end
      ST_WAIT_HS: begin
        if (rx_pid_en && (rx_pid == PID_ACK || rx_pid == PID_NAK || rx_pid == PID_STALL)) begin
          state_d  = ST_IDLE;
          tog_flip = (rx_pid == PID_ACK);
        end else if (expired) begin
          state_d = ST_IDLE;
          to_fire = 1'b1;
        end
      end
      ST_TURN:  if (turn_done) state_d = ret_q;
      ST_TX_HS: if (tx_lp_eop_en) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // State, transaction context, response timer and turnaround counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      ret_q    <= ST_IDLE;
      tok_q    <= '0;
      ep_q     <= '0;
      timer_q  <= '0;
      delay_q  <= '0;
      frozen_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
      if (state_q == ST_IDLE) begin
        ep_q  <= ep_sel;
        tok_q <= ms ? tx_con_pid : rx_pid;
      end
      if ((state_d == ST_WAIT_DATA || state_d == ST_WAIT_HS) && state_d != state_q)
        timer_q <= '0;
      else if ((state_q == ST_WAIT_DATA || state_q == ST_WAIT_HS) && !hold)
        timer_q <= timer_q + TIMER_W'(1);
      if (rx_pid_en)      frozen_q <= 1'b0;
      else if (rx_sop_en) frozen_q <= 1'b1;
      if (state_d == ST_TURN && state_q != ST_TURN) delay_q <= '0;
      else if (state_q == ST_TURN)                  delay_q <= delay_q + DELAY_W'(1);
    end
  end

  // Registered outputs decoded from the state being entered
  always_ff @(posedge clk) begin
    if (rst) begin
      d_oe            <= 1'b0;
      tx_data_on      <= 1'b0;
      rx_data_on      <= 1'b0;
      rx_handshake_on <= 1'b0;
      time_out        <= 1'b0;
      toggle_err      <= 1'b0;
      tx_data_pid     <= PID_DATA0;
    end else begin
      d_oe            <= (state_d == ST_TX_TOKEN) || (state_d == ST_TX_DATA) || (state_d == ST_TX_HS);
      tx_data_on      <= (state_d == ST_TX_DATA);
      rx_data_on      <= (state_d == ST_WAIT_DATA);
      rx_handshake_on <= (state_d == ST_WAIT_HS);
      time_out        <= to_fire;
      toggle_err      <= terr;
      tx_data_pid     <= tog_sel ? PID_DATA1 : PID_DATA0;
    end
  end

`ifdef LINK_CTRL_RETRY_EN
  localparam int CNT_W = $clog2(MAX_RETRY + 1);
  logic             role_q, retry_ev, retry_clr;
  logic [CNT_W-1:0] retry_q;

  assign nak_abort = role_q && rx_pid_en && (rx_pid == PID_NAK);
  assign retry_ev  = role_q && (to_fire || (rx_pid_en && rx_pid == PID_NAK &&
                     (state_q == ST_WAIT_HS || state_q == ST_WAIT_DATA)));
  assign retry_clr = role_q && rx_pid_en && state_q == ST_WAIT_HS &&
                     (rx_pid == PID_ACK || rx_pid == PID_STALL);

  // Retry budget: count NAK/timeout in host role, fail and restart once the budget is spent
  always_ff @(posedge clk) begin
    if (rst) begin
      role_q     <= 1'b0;
      retry_q    <= '0;
      retry_req  <= 1'b0;
      retry_fail <= 1'b0;
    end else begin
      if (state_q == ST_IDLE) role_q <= ms;
      retry_req  <= 1'b0;
      retry_fail <= 1'b0;
      if (retry_ev) begin
        if (retry_q == CNT_W'(MAX_RETRY)) begin
          retry_fail <= 1'b1;
          retry_q    <= '0;
        end else begin
          retry_req <= 1'b1;
          retry_q   <= retry_q + CNT_W'(1);
        end
      end else if (retry_clr) begin
        retry_q <= '0;
      end
    end
  end
`else
  assign nak_abort  = 1'b0;
  assign retry_req  = 1'b0;
  assign retry_fail = 1'b0;
`endif

endmodule

// File: tb/tb_link_control_mp.sv
// tb/tb_link_control_mp.sv - scoreboard bench: expected output-vector changes queued with their cycle
module tb_link_control_mp;
  import usb_link_pkg::*;

  logic        clk = 1'b0;
  logic        rst, ms, rx_pid_en, rx_sop_en, tx_con_pid_en, tx_lp_eop_en;
  logic [3:0]  rx_pid, tx_con_pid;
  logic [1:0]  ep_sel;
  logic [5:0]  delay_threshold;
  logic [15:0] time_threshold;
  logic        rx_handshake_on, rx_data_on, d_oe, tx_data_on;
  logic [3:0]  tx_data_pid;
  logic        time_out, toggle_err, retry_req, retry_fail;

  link_control_mp dut (
    .clk(clk), .rst(rst), .ms(ms), .rx_pid(rx_pid), .rx_pid_en(rx_pid_en),
    .rx_sop_en(rx_sop_en), .ep_sel(ep_sel), .delay_threshold(delay_threshold),
    .time_threshold(time_threshold), .tx_con_pid(tx_con_pid), .tx_con_pid_en(tx_con_pid_en),
    .tx_lp_eop_en(tx_lp_eop_en), .rx_handshake_on(rx_handshake_on), .rx_data_on(rx_data_on),
    .d_oe(d_oe), .tx_data_on(tx_data_on), .tx_data_pid(tx_data_pid), .time_out(time_out),
    .toggle_err(toggle_err), .retry_req(retry_req), .retry_fail(retry_fail)
  );

  always #5 clk = ~clk;

  // {hs_on, data_on, d_oe, tx_data_on, tx_data_pid, time_out, toggle_err, retry_req, retry_fail}
  logic [11:0] vec;
  assign vec = {rx_handshake_on, rx_data_on, d_oe, tx_data_on, tx_data_pid,
                time_out, toggle_err, retry_req, retry_fail};

`ifdef LINK_CTRL_RETRY_EN
  localparam logic [11:0] RQM = 12'h002;
  localparam logic [11:0] RFM = 12'h001;
`else
  localparam logic [11:0] RQM = 12'h000;
  localparam logic [11:0] RFM = 12'h000;
`endif

  typedef struct { int c; logic [11:0] v; } exp_t;
  exp_t        sb[$];
  exp_t        mon_e;
  logic [11:0] prev = 12'h000;
  int          cyc = 0;
  int          total = 0;
  int          bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every change of the output vector must match the next queued expectation
  always @(negedge clk) begin
    if (!$isunknown(vec) && vec !== prev) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_change cyc=%0d got=%03h want=no_change", cyc, vec);
      end else begin
        mon_e = sb.pop_front();
        if (mon_e.v !== vec || mon_e.c != cyc) begin
          bad++;
          $display("FAIL out_change got=%03h@%0d want=%03h@%0d", vec, cyc, mon_e.v, mon_e.c);
        end
      end
      prev = vec;
    end
  end

  task automatic push_exp(input int off, input logic [11:0] v);
    exp_t e;
    e.c = cyc + off;
    e.v = v;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic tx_pid(input logic [3:0] p);
    tx_con_pid = p; tx_con_pid_en = 1'b1; tick(); tx_con_pid_en = 1'b0;
  endtask

  task automatic tx_eop();
    tx_lp_eop_en = 1'b1; tick(); tx_lp_eop_en = 1'b0;
  endtask

  task automatic rxp(input logic [3:0] p);
    rx_pid = p; rx_pid_en = 1'b1; tick(); rx_pid_en = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [11:0] ev;
    rst = 1'b1; ms = 1'b1; ep_sel = 2'd2; delay_threshold = 6'd5; time_threshold = 16'd20;
    rx_pid = 4'h0; rx_pid_en = 1'b0; rx_sop_en = 1'b0;
    tx_con_pid = 4'h0; tx_con_pid_en = 1'b0; tx_lp_eop_en = 1'b0;
    push_exp(1, 12'h030);
    idle(3);
    rst = 1'b0;
    idle(2);

    // host OUT on ep 2, ACK flips toggle -> DATA1
    push_exp(1, 12'h230); tx_pid(PID_OUT);
    push_exp(1, 12'h330); tx_eop();
    push_exp(1, 12'h830); tx_eop();
    push_exp(1, 12'h030); push_exp(2, 12'h0B0); rxp(PID_ACK);
    idle(3);

    // device IN on ep 2 with 5-cycle turnaround, sends DATA1, ACK flips back
    ms = 1'b0; tick();
    push_exp(6, 12'h3B0); rxp(PID_IN);
    idle(5);
    push_exp(1, 12'h8B0); tx_eop();
    push_exp(1, 12'h0B0); push_exp(2, 12'h030); rxp(PID_ACK);
    idle(3);

    // host IN on ep 1, no reply: time_out 20 cycles after entering WAIT_DATA
    ms = 1'b1; ep_sel = 2'd1; tick();
    push_exp(1, 12'h230); tx_pid(PID_IN);
    push_exp(1, 12'h430); push_exp(21, 12'h038 | RQM); push_exp(22, 12'h030); tx_eop();
    idle(25);

    // host IN again; SOP freezes the timer, DATA0 accepted late, toggle flips, TX_HS after turn
    push_exp(1, 12'h230); tx_pid(PID_IN);
    push_exp(1, 12'h430); push_exp(31, 12'h030); push_exp(32, 12'h0B0); push_exp(36, 12'h2B0);
    tx_eop();
    idle(4);
    rx_sop_en = 1'b1; tick(); rx_sop_en = 1'b0;
    idle(24);
    rxp(PID_DATA0);
    idle(5);
    push_exp(1, 12'h0B0); tx_eop();
    idle(3);

    // device OUT on ep 3, stray ACK ignored, DATA1 vs expected DATA0, zero-length turnaround
    ms = 1'b0; ep_sel = 2'd3; delay_threshold = 6'd0;
    push_exp(1, 12'h030); tick();
    push_exp(1, 12'h430); rxp(PID_OUT);
    rxp(PID_ACK);
    push_exp(1, 12'h034); push_exp(2, 12'h230); rxp(PID_DATA1);
    tick();
    push_exp(1, 12'h030); tx_eop();
    idle(3);

    // host SETUP on ep 1 clears its toggle; data goes out as DATA0; STALL leaves it
    ms = 1'b1; ep_sel = 2'd1; delay_threshold = 6'd5;
    push_exp(1, 12'h0B0); tick();
    push_exp(1, 12'h2B0); push_exp(2, 12'h330); tx_pid(PID_SETUP);
    tx_eop();
    push_exp(1, 12'h830); tx_eop();
    push_exp(1, 12'h030); rxp(PID_STALL);
    idle(2);

    // host OUT ep 0 to set its toggle, then reset in the middle of TX_DATA
    ep_sel = 2'd0; tick();
    push_exp(1, 12'h230); tx_pid(PID_OUT);
    push_exp(1, 12'h330); tx_eop();
    push_exp(1, 12'h830); tx_eop();
    push_exp(1, 12'h030); push_exp(2, 12'h0B0); rxp(PID_ACK);
    idle(2);
    push_exp(1, 12'h2B0); tx_pid(PID_OUT);
    push_exp(1, 12'h3B0); tx_eop();
    push_exp(1, 12'h030); rst = 1'b1; tick(); rst = 1'b0;
    idle(4);

    // four NAKed host OUTs: retry pulses then a failure when the budget is enabled
    for (int i = 0; i < 4; i++) begin
      push_exp(1, 12'h230); tx_pid(PID_OUT);
      push_exp(1, 12'h330); tx_eop();
      push_exp(1, 12'h830); tx_eop();
      ev = (i == 3) ? RFM : RQM;
      push_exp(1, 12'h030 | ev);
      if (ev != 12'h000) push_exp(2, 12'h030);
      rxp(PID_NAK);
      idle(2);
    end

    idle(3);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL pending_expectations got=%0d want=0 next_cyc=%0d", sb.size(), sb[0].c);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/link_control_mp.md
# link_control_mp

Parametrised successor to the USB 2.0 link-layer transaction controller. It sequences token, data and handshake phases for host (master) and device (slave) roles, and owns bus turnaround (`d_oe`), the inter-packet delay and the response timeout. It adds per-endpoint DATA0/DATA1 toggle tracking and, optionally, bounded retry on timeout or NAK. It sits between the PID decoder / packet receiver and the packet transmitter.

## Interface
Parameters:
- `NUM_EP`, default 4: number of endpoints with a tracked toggle bit; must be at least 1.
- `EP_W`, default 2: endpoint index width; `2**EP_W >= NUM_EP`.
- `DELAY_W`, default 6: width of the inter-packet delay counter.
- `TIMER_W`, default 16: width of the timeout timer.
- `MAX_RETRY`, default 3: retry budget per transaction.

Ports:
- `clk` in 1: clock. One clock domain; reset is synchronous and active-high.
- `rst` in 1: synchronous active-high reset.
- `ms` in 1: role select, 1 = master (host), 0 = slave. Sampled only in IDLE.
- `rx_pid` in 4: received PID, valid when `rx_pid_en` is high.
- `rx_pid_en` in 1: one-cycle strobe.
- `rx_sop_en` in 1: receive start-of-packet strobe.
- `ep_sel` in EP_W: endpoint of the current token, sampled with the token PID.
- `delay_threshold` in DELAY_W: turnaround delay in cycles.
- `time_threshold` in TIMER_W: response timeout in cycles; 0 is treated as 1.
- `tx_con_pid` in 4: PID being transmitted, valid when `tx_con_pid_en` is high.
- `tx_con_pid_en` in 1: transmit PID strobe.
- `tx_lp_eop_en` in 1: transmit end-of-packet strobe.
- `rx_handshake_on` out 1: expecting a handshake.
- `rx_data_on` out 1: expecting a data packet.
- `d_oe` out 1: transmit driver enable.
- `tx_data_on` out 1: permission to send a data packet.
- `tx_data_pid` out 4: DATA0 (0011) or DATA1 (1011) for `ep_sel`'s toggle.
- `time_out` out 1: one-cycle pulse.
- `toggle_err` out 1: one-cycle pulse.
- `retry_req` out 1: one-cycle pulse.
- `retry_fail` out 1: one-cycle pulse.

## Operation
- **States:** IDLE, TX_TOKEN, TX_DATA, WAIT_DATA, WAIT_HS, TURN, TX_HS. All outputs are registered.
- **Master path:**
  - IDLE → TX_TOKEN on `tx_con_pid_en` with a token PID (OUT 0001, IN 1001, SETUP 1101).
  - TX_TOKEN → on `tx_lp_eop_en`: OUT or SETUP → TX_DATA; IN → WAIT_DATA.
  - TX_DATA → WAIT_HS on `tx_lp_eop_en`.
  - WAIT_HS → IDLE on a received ACK, NAK or STALL.
  - WAIT_DATA → TURN on a received DATAx, with next state TX_HS.
- **Slave path:**
  - IDLE → on a received token: OUT or SETUP → WAIT_DATA; IN → TURN, with next state TX_DATA.
  - WAIT_DATA → TURN on DATAx, with next state TX_HS.
  - TX_DATA → WAIT_HS on `tx_lp_eop_en`.
  - WAIT_HS → IDLE on a received handshake.
- **TX_HS:** → IDLE on `tx_lp_eop_en`.
- **TURN:** counts `delay_threshold` cycles with `d_oe` low, then enters the stored next state. A threshold of 0 means one cycle.
- **Output levels by state:**
  - `d_oe` is high in TX_TOKEN, TX_DATA and TX_HS.
  - `tx_data_on` is high in TX_DATA.
  - `rx_data_on` is high in WAIT_DATA.
  - `rx_handshake_on` is high in WAIT_HS.
- **Timeout:** The timer clears on entry to WAIT_DATA or WAIT_HS and increments each cycle. When it equals `time_threshold`, `time_out` pulses and the FSM goes to IDLE.
  - `rx_sop_en` freezes the timer until the next `rx_pid_en`.
- **Toggles:**
  - Held in `NUM_EP` flops. SETUP clears the toggle of `ep_sel`.
  - Sender side: ACK received in WAIT_HS flips it.
  - Receiver side: a matching DATAx accepted in WAIT_DATA flips it.
  - A mismatched DATAx pulses `toggle_err`, leaves the toggle unchanged, and continues the handshake normally.
  - `ep_sel >= NUM_EP` is ignored: no toggle update and `tx_data_pid` = DATA0.
- **Unexpected PIDs:** ignored in every state.
- **Reset:** Reset while mid-transaction returns to IDLE on the next edge. Reset values:
  - All outputs 0, except `tx_data_pid` = 0011.
  - All toggles 0, timer 0, delay counter 0, retry count 0.

## Timing
- A state change takes effect on the edge after the triggering strobe; outputs change one cycle after that strobe.
- `time_out` asserts exactly `time_threshold` cycles after entering the wait state.
- If `rx_pid_en` and the timeout fall in the same cycle, the PID wins and no `time_out` is generated.
- TURN lasts `max(delay_threshold,1)` cycles; `d_oe` rises on the first cycle of the following TX state.

## Configuration
- **`LINK_CTRL_RETRY_EN` defined:**
  - In master mode, `time_out` or a NAK in WAIT_HS/WAIT_DATA increments the retry count and pulses `retry_req` in the same cycle `time_out` would pulse.
  - When the count reaches `MAX_RETRY`, `retry_fail` pulses instead and the count clears.
  - ACK or STALL clears the count.
- **Not defined:** `retry_req` and `retry_fail` are tied to 0 and no counter is built.

## Structure
- **Shared package `usb_link_pkg`:**
  - 4-bit PID constants (OUT, IN, SETUP, DATA0, DATA1, ACK, NAK, STALL).
  - State encoding typedef.
  - `is_token` and `is_data` helper functions.
- **One sub-module, `link_toggle_bank`:** `NUM_EP` toggle flops with clear/flip/read by index.

## Test plan
- **Master OUT:** master OUT token, data, ACK on ep 2 → toggle[2] goes 0→1; `tx_data_pid` 0011 then 1011.
- **Slave IN:** slave IN with `delay_threshold`=5 → `d_oe` rises exactly 5 cycles after the IN `rx_pid_en`+1; `tx_data_on` is high until `tx_lp_eop_en`.
- **Timeout:** master IN, no reply, `time_threshold`=20 → `time_out` pulses on the 20th WAIT_DATA cycle, then IDLE.
- **Retry (macro on):** `MAX_RETRY`=3 → three NAKs give three `retry_req` pulses; a fourth NAK gives `retry_fail`.
- **Toggle mismatch:** slave receives DATA1 while expecting DATA0 → `toggle_err` pulses, TX_HS entered, toggle stays 0.
- **Reset mid-TX_DATA:** `rst` asserted → all outputs 0 next cycle, toggles cleared.
